// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared widths and lane type for the UART byte-to-word path.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int LANES  = 4;

  typedef logic [1:0] lane_t;

  // Map the arrival-order lane count onto the physical byte slot of the word.
  function automatic lane_t lane_slot(input lane_t lane, input bit little_endian);
    lane_t slot;
    if (little_endian) slot = lane;
    else               slot = 2'd3 - lane;
    return slot;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : First-word-fall-through synchronous FIFO with occupancy count.
//               A push into a full FIFO is accepted only when a pop happens
//               in the same cycle; otherwise it is refused.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [4:0]       level
);

  localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] C_DEPTH = 5'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [4:0]       count_q;

  logic w_do_push;
  logic w_do_pop;

  assign full  = (count_q == C_DEPTH);
  assign empty = (count_q == 5'd0);
  assign level = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Pop only real data; a full FIFO can take a push only while it drains.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 5'd0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + 5'd1;
        2'b01:   count_q <= count_q - 5'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/byte_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_word_packer
// Description : Packs a strobed byte stream into 32-bit words, with flush of
//               partial words, and queues them in a word FIFO. Words that
//               arrive while the FIFO is full (and not draining) are dropped
//               and latched in a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_word_packer
  import uart_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_in_stb,
  input  logic              flush,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [1:0]        lane,
  output logic [4:0]        level,
  output logic              overflow
);

  lane_t             lane_q, lane_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic              overflow_q, overflow_d;

  logic [WORD_W-1:0] w_acc_merged;
  lane_t             w_slot;
  logic              w_word_done;
  logic              w_flush_push;
  logic              w_push;
  logic              w_drop;
  logic              w_full;
  logic              w_empty;

  assign w_slot = lane_slot(lane_q, LITTLE_ENDIAN);

  // Assembly register with the incoming byte merged into its slot.
  always_comb begin
    w_acc_merged = acc_q;
    if (byte_in_stb) begin
      for (int k = 0; k < LANES; k++) begin
        if (w_slot == lane_t'(k)) begin
          w_acc_merged[k*BYTE_W +: BYTE_W] = byte_in;
        end
      end
    end
  end

  // A word goes out on the 4th byte, or on flush when there is anything to
  // send (including a byte arriving in the same cycle). Both together still
  // make exactly one push of the merged word.
  assign w_word_done  = byte_in_stb && (lane_q == 2'd3);
  assign w_flush_push = flush && (byte_in_stb || (lane_q != 2'd0));
  assign w_push       = w_word_done || w_flush_push;

  // A full FIFO only accepts when the consumer pops in the same cycle.
  assign w_drop = w_push && w_full && !word_ready;

  // Next-state for lane counter, assembly register and sticky overflow.
  // The register is cleared on every push so unfilled lanes pad with zero.
  always_comb begin
    lane_d     = lane_q;
    acc_d      = acc_q;
    overflow_d = overflow_q | w_drop;
    if (w_push) begin
      lane_d = 2'd0;
      acc_d  = '0;
    end else if (byte_in_stb) begin
      lane_d = lane_q + 2'd1;
      acc_d  = w_acc_merged;
    end
  end

  // State registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q     <= 2'd0;
      acc_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      lane_q     <= lane_d;
      acc_q      <= acc_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (word_ready),
    .wdata (w_acc_merged),
    .rdata (word_out),
    .full  (w_full),
    .empty (w_empty),
    .level (level)
  );

  assign word_valid = !w_empty;
  assign lane       = lane_q;
  assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_word_packer
// Description : Self-checking bench. Two instances (little- and big-endian)
//               share the same stimulus; a queue-based model tracks bytes
//               received, words queued and the overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_word_packer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_in_stb = 1'b0;
  logic        flush = 1'b0;
  logic        word_ready = 1'b0;

  logic [31:0] word_le, word_be;
  logic        valid_le, valid_be;
  logic [1:0]  lane_le, lane_be;
  logic [4:0]  level_le, level_be;
  logic        ovf_le, ovf_be;

  int n_vec = 0;
  int n_bad = 0;

  // Model state
  logic [31:0] m_q[$];      // queued words, little-endian packing
  logic [7:0]  m_bytes[$];  // bytes of the partial word, arrival order
  logic        m_ovf = 1'b0;

  always #5 clk = ~clk;

  byte_word_packer #(.DEPTH(DEPTH), .LITTLE_ENDIAN(1'b1)) dut_le (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_in_stb(byte_in_stb),
    .flush(flush), .word_out(word_le), .word_valid(valid_le),
    .word_ready(word_ready), .lane(lane_le), .level(level_le), .overflow(ovf_le)
  );

  byte_word_packer #(.DEPTH(DEPTH), .LITTLE_ENDIAN(1'b0)) dut_be (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_in_stb(byte_in_stb),
    .flush(flush), .word_out(word_be), .word_valid(valid_be),
    .word_ready(word_ready), .lane(lane_be), .level(level_be), .overflow(ovf_be)
  );

  typedef struct {
    logic        stb;
    logic [7:0]  b;
    logic        fl;
    logic        rdy;
    int          e_lane;
    int          e_level;
    logic        e_valid;
    logic [31:0] e_word;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [31:0] mkword(input int n);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(n * 16);
    b1 = 8'(n * 16 + 1);
    b2 = 8'(n * 16 + 2);
    b3 = 8'(n * 16 + 3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_bytes.delete();
    m_ovf = 1'b0;
  endtask

  task automatic model_update(input logic s, input logic [7:0] b, input logic f, input logic r);
    bit          full_before;
    bit          pop;
    bit          push;
    logic [31:0] w;
    full_before = (m_q.size() == DEPTH);
    pop = r && (m_q.size() > 0);
    if (pop) void'(m_q.pop_front());
    if (s) m_bytes.push_back(b);
    push = (m_bytes.size() == 4) || (f && (m_bytes.size() > 0));
    if (push) begin
      w = 32'h0;
      foreach (m_bytes[i]) w = w | (32'(m_bytes[i]) << (8 * i));
      m_bytes.delete();
      if (full_before && !pop) m_ovf = 1'b1;
      else                     m_q.push_back(w);
    end
  endtask

  task automatic compare_all();
    chk("lane_le",  32'(lane_le),  32'(m_bytes.size()));
    chk("lane_be",  32'(lane_be),  32'(m_bytes.size()));
    chk("level_le", 32'(level_le), 32'(m_q.size()));
    chk("level_be", 32'(level_be), 32'(m_q.size()));
    chk("valid_le", 32'(valid_le), 32'(m_q.size() > 0));
    chk("valid_be", 32'(valid_be), 32'(m_q.size() > 0));
    chk("ovf_le",   32'(ovf_le),   32'(m_ovf));
    chk("ovf_be",   32'(ovf_be),   32'(m_ovf));
    if (m_q.size() > 0) begin
      chk("word_le", word_le, m_q[0]);
      chk("word_be", word_be, bswap(m_q[0]));
    end
  endtask

  // Drive one cycle of inputs, update the model at the edge, check at negedge.
  task automatic step(input logic s, input logic [7:0] b, input logic f, input logic r);
    byte_in_stb = s;
    byte_in     = b;
    flush       = f;
    word_ready  = r;
    @(posedge clk);
    model_update(s, b, f, r);
    @(negedge clk);
    byte_in_stb = 1'b0;
    flush       = 1'b0;
    word_ready  = 1'b0;
    compare_all();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    compare_all();
    chk("rst_word_le", word_le, 32'h0);
    chk("rst_word_be", word_be, 32'h0);
  endtask

  task automatic send_word(input int n, input logic r);
    logic [31:0] w;
    w = mkword(n);
    for (int i = 0; i < 4; i++) step(1'b1, w[8*i +: 8], 1'b0, r);
  endtask

  initial begin
    // Directed table: full word, pop, partial flush, idle flush, pop.
    tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 0, 1'b0, 32'h0,        1'b0};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 2, 0, 1'b0, 32'h0,        1'b0};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b0, 3, 0, 1'b0, 32'h0,        1'b0};
    tbl[3] = '{1'b1, 8'h44, 1'b0, 1'b0, 0, 1, 1'b1, 32'h44332211, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 0, 1'b0, 32'h0,        1'b0};
    tbl[5] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1, 0, 1'b0, 32'h0,        1'b0};
    tbl[6] = '{1'b1, 8'hBB, 1'b0, 1'b0, 2, 0, 1'b0, 32'h0,        1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1, 1'b1, 32'h0000BBAA, 1'b0};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1, 1'b1, 32'h0000BBAA, 1'b0};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 0, 1'b0, 32'h0,        1'b0};

    reset = 1'b1;
    #12;
    apply_reset();

    foreach (tbl[i]) begin
      step(tbl[i].stb, tbl[i].b, tbl[i].fl, tbl[i].rdy);
      chk("tbl_lane",  32'(lane_le),  32'(tbl[i].e_lane));
      chk("tbl_level", 32'(level_le), 32'(tbl[i].e_level));
      chk("tbl_valid", 32'(valid_le), 32'(tbl[i].e_valid));
      chk("tbl_ovf",   32'(ovf_le),   32'(tbl[i].e_ovf));
      if (tbl[i].e_valid) chk("tbl_word", word_le, tbl[i].e_word);
    end

    // Overflow: five words into a depth-4 FIFO with no consumer.
    apply_reset();
    for (int n = 1; n <= 5; n++) send_word(n, 1'b0);
    chk("ovf_level", 32'(level_le), 32'd4);
    chk("ovf_flag",  32'(ovf_le),   32'd1);
    chk("ovf_lane",  32'(lane_le),  32'd0);
    for (int n = 1; n <= 4; n++) begin
      chk("ovf_order", word_le, mkword(n));
      step(1'b0, 8'h00, 1'b0, 1'b1);
    end
    chk("ovf_empty", 32'(valid_le), 32'd0);
    chk("ovf_sticky", 32'(ovf_le), 32'd1);

    // Push and pop together while full: accepted, no overflow.
    apply_reset();
    for (int n = 1; n <= 4; n++) send_word(n, 1'b0);
    begin
      logic [31:0] w5;
      w5 = mkword(5);
      for (int i = 0; i < 3; i++) step(1'b1, w5[8*i +: 8], 1'b0, 1'b0);
      step(1'b1, w5[31:24], 1'b0, 1'b1);
    end
    chk("pp_level", 32'(level_le), 32'd4);
    chk("pp_ovf",   32'(ovf_le),   32'd0);
    for (int n = 2; n <= 5; n++) begin
      chk("pp_order", word_le, mkword(n));
      step(1'b0, 8'h00, 1'b0, 1'b1);
    end

    // Asynchronous reset mid-word, between clock edges.
    apply_reset();
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_lane",  32'(lane_le),  32'd0);
    chk("arst_valid", 32'(valid_le), 32'd0);
    chk("arst_level", 32'(level_le), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 8'hDE, 1'b0, 1'b0);
    step(1'b1, 8'hAD, 1'b0, 1'b0);
    step(1'b1, 8'hBE, 1'b0, 1'b0);
    step(1'b1, 8'hEF, 1'b0, 1'b0);
    chk("arst_word", word_le, 32'hEFBEADDE);

    // Fourth byte coincident with flush, big-endian: exactly one push.
    apply_reset();
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b1, 8'h03, 1'b0, 1'b0);
    step(1'b1, 8'h04, 1'b1, 1'b0);
    chk("be_word",  word_be, 32'h01020304);
    chk("be_level", 32'(level_be), 32'd1);
    chk("be_lane",  32'(lane_be),  32'd0);
    // Strobe at lane 0 with flush pushes a one-byte word.
    step(1'b1, 8'h77, 1'b1, 1'b1);
    chk("fl0_level", 32'(level_le), 32'd1);
    chk("fl0_word",  word_le, 32'h00000077);

    // Randomised traffic against the model.
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        apply_reset();
      end else begin
        step(1'($urandom_range(0, 1)), 8'($urandom),
             1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/byte_word_packer.md
BYTE_WORD_PACKER -- requirements
Module: byte_word_packer

Interface
REQ-001 Parameter DEPTH, default 4, word-FIFO depth; SHALL be a power of two, 2 to 16.
REQ-002 Parameter LITTLE_ENDIAN, default 1; 1 = first received byte goes to bits [7:0], 0 = first byte goes to bits [31:24].
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 byte_in  input  8  received byte, as driven by the UART receive stream.
REQ-006 byte_in_stb  input  1  one-cycle strobe, byte_in valid; no backpressure is possible.
REQ-007 flush  input  1  one-cycle request to commit a partial word.
REQ-008 word_out  output  32  FIFO head word; valid only while word_valid=1.
REQ-009 word_valid  output  1  FIFO not empty.
REQ-010 word_ready  input  1  consumer accepts word_out when word_valid=1 and word_ready=1 (pop).
REQ-011 lane  output  2  number of bytes held in the partial word, 0 to 3.
REQ-012 level  output  5  FIFO occupancy, 0 to DEPTH.
REQ-013 overflow  output  1  sticky flag; a completed word was dropped.

Function
REQ-014 Assembly: each byte_in_stb SHALL write byte_in into the lane selected by lane and LITTLE_ENDIAN, then increment lane.
REQ-015 Completion: a strobe with lane=3 SHALL form the complete word, push it, and wrap lane to 0 in the same edge.
REQ-016 Latency: word_valid SHALL rise the cycle after the 4th strobe when the FIFO was empty (FIFO is first-word-fall-through).
REQ-017 Flush with lane=0 and no strobe: no effect.
REQ-018 Flush with lane>0: push the partial word with unfilled lanes zero, then set lane=0.
REQ-019 Flush coincident with a strobe: the byte SHALL be included first, then the word padded and pushed; exactly one push results, including when lane=3.
REQ-020 Push when full: the word SHALL be dropped, overflow set, lane still wraps to 0, and FIFO contents are unchanged.
REQ-021 Push and pop in the same cycle while full: the push SHALL succeed, level stays DEPTH, and overflow is unchanged.
REQ-022 Pop when empty: ignored; level stays 0.
REQ-023 FIFO order SHALL be strict FIFO; read and write pointers wrap modulo DEPTH.
REQ-024 level SHALL equal pushes minus pops, saturating neither below 0 nor above DEPTH.
REQ-025 overflow SHALL clear only on reset.

Reset
REQ-026 Reset asserted SHALL immediately force the following, regardless of clk: lane=0, level=0, word_valid=0, overflow=0, FIFO pointers 0, partial word 0.
REQ-027 word_out SHALL read 0 after reset until the first push.
REQ-028 Reset mid-word SHALL discard the partial bytes; the first strobe after release goes to lane 0.
REQ-029 Reset release SHALL take effect at the first clk edge after deassertion; no strobe is lost after that edge.

Structure
REQ-030 Shared package uart_pkg SHALL hold: BYTE_W=8, WORD_W=32, LANES=4, and lane_t (2-bit) typedef.
REQ-031 The FIFO SHALL be one sub-module, sync_fifo, parameterised by width and DEPTH, with full/empty/level outputs.
REQ-032 Assembly register, lane counter, and flush logic SHALL live in byte_word_packer; no other sub-modules.

Verification
REQ-033 Strobes 0x11,0x22,0x33,0x44, LITTLE_ENDIAN=1 -> word_out=0x44332211, word_valid=1 one cycle after the 4th strobe, lane=0.
REQ-034 Strobes 0xAA,0xBB, then flush -> word_out=0x0000BBAA, level=1, lane=0; a flush with lane=0 -> level unchanged.
REQ-035 DEPTH=4, word_ready=0, 5 words sent -> level=4, overflow=1, and popped sequence equals words 1-4.
REQ-036 FIFO full, 4th byte strobe coincident with word_ready=1 -> level stays 4, overflow=0, new word at tail.
REQ-037 Two bytes received, then reset pulsed asynchronously between edges -> lane=0 and word_valid=0 at once; next 4 bytes form a clean word.
REQ-038 Strobe with lane=3 coincident with flush, LITTLE_ENDIAN=0, bytes 0x01,0x02,0x03,0x04 -> exactly one push, word_out=0x01020304.
